conv33_line_buffer: RTL and testbench

- Streaming front-end for the 3x3 convolution window stage.
- Accepts one pixel per valid cycle in raster order and keeps the two previous image rows in circular line memories.
- Each accepted pixel emits one vertical 3-pixel column (top/mid/bot) plus a shift enable, which drive the window stage's in1/in2/in3 and en.
- Flags the cycles where the downstream convolution result is a valid full 3x3 window, and marks frame completion.

---
 rtl/conv_pkg.sv | 29 ++
 rtl/conv_line_ram.sv | 38 +++
 rtl/conv33_line_buffer.sv | 163 ++++++++++++++++
 tb/tb_conv33_line_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared definitions for the 3x3 convolution front-end.
//   - DEF_* defaults for pixel width and image geometry
//   - clog2() used to size the column/row counters and line-RAM addresses
//   - pixel_t: signed pixel at the default width
// ---------------------------------------------------------------------------
package conv_pkg;

  localparam int unsigned DEF_BIT_WIDTH = 8;
  localparam int unsigned DEF_IMG_W     = 28;
  localparam int unsigned DEF_IMG_H     = 28;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned DEF_COL_W = clog2(DEF_IMG_W);
  localparam int unsigned DEF_ROW_W = clog2(DEF_IMG_H);

  typedef logic signed [DEF_BIT_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/conv_line_ram.sv
// ---------------------------------------------------------------------------
// conv_line_ram
//   One image row of pixel storage, DEPTH x WIDTH, single address port.
//   Read is combinational from the current address; write lands on the
//   rising edge, so a same-cycle read returns the value before the write.
//   Contents are not reset.
//
//   clk      in   clock
//   we_i     in   write enable
//   addr_i   in   read/write address (column)
//   wdata_i  in   write data
//   rdata_o  out  read data at addr_i (pre-write value)
// ---------------------------------------------------------------------------
module conv_line_ram
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_IMG_W,
  parameter int unsigned WIDTH  = DEF_BIT_WIDTH,
  parameter int unsigned ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv33_line_buffer.sv
// ---------------------------------------------------------------------------
// conv33_line_buffer
//   Raster-order pixel stream in, one vertical 3-pixel column out per
//   accepted pixel for the 3x3 window stage. Two circular line RAMs hold the
//   previous two rows; each accept shifts the column at that address down
//   (line0 -> line1, pixel -> line0).
//
//   clk         in   clock
//   rst_n       in   async active-low reset
//   sof         in   start of frame, qualified by pix_valid
//   pix_valid   in   pixel strobe (always accepted)
//   pix_in      in   pixel (signed; passed through bit-exact)
//   col_en      out  window-stage shift enable, one cycle after accept
//   out_top     out  pixel from row r-2
//   out_mid     out  pixel from row r-1
//   out_bot     out  current pixel
//   win_valid   out  window stage output is a full valid 3x3 window
//   frame_done  out  pulse with col_en of the last pixel of the frame
// ---------------------------------------------------------------------------
module conv33_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int unsigned IMG_W     = DEF_IMG_W,
  parameter int unsigned IMG_H     = DEF_IMG_H
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sof,
  input  logic                 pix_valid,
  input  logic [BIT_WIDTH-1:0] pix_in,
  output logic                 col_en,
  output logic [BIT_WIDTH-1:0] out_top,
  output logic [BIT_WIDTH-1:0] out_mid,
  output logic [BIT_WIDTH-1:0] out_bot,
  output logic                 win_valid,
  output logic                 frame_done
);

  localparam int unsigned COL_W = clog2(IMG_W);
  localparam int unsigned ROW_W = clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Position of the pixel being accepted this cycle; sof forces (0,0).
  logic [COL_W-1:0] pos_col;
  logic [ROW_W-1:0] pos_row;
  logic             at_last_col;
  logic             at_last_row;
  logic             win_now;

  logic [BIT_WIDTH-1:0] line0_rd;
  logic [BIT_WIDTH-1:0] line1_rd;

  logic [BIT_WIDTH-1:0] top_q, top_d;
  logic [BIT_WIDTH-1:0] mid_q, mid_d;
  logic [BIT_WIDTH-1:0] bot_q, bot_d;
  logic                 col_en_q;
  logic                 win_pend_q;
  logic                 win_valid_q;
  logic                 frame_done_q;

  always_comb begin
    pos_col     = sof ? '0 : col_q;
    pos_row     = sof ? '0 : row_q;
    at_last_col = (pos_col == COL_LAST);
    at_last_row = (pos_row == ROW_LAST);
    // Only windows fully inside the current frame's rows/cols qualify,
    // which also keeps stale line-RAM contents from ever being flagged.
    win_now     = (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (at_last_col) begin
        col_d = '0;
        row_d = at_last_row ? '0 : pos_row + ROW_W'(1);
      end else begin
        col_d = pos_col + COL_W'(1);
        row_d = pos_row;
      end
    end
  end

  always_comb begin
    top_d = top_q;
    mid_d = mid_q;
    bot_d = bot_q;
    if (pix_valid) begin
      top_d = line1_rd;
      mid_d = line0_rd;
      bot_d = pix_in;
    end
  end

  // line1 takes line0's old value at the same column before line0 is
  // overwritten, so the column shifts down by one row per accept.
  conv_line_ram #(
    .DEPTH  (IMG_W),
    .WIDTH  (BIT_WIDTH),
    .ADDR_W (COL_W)
  ) u_line0 (
    .clk     (clk),
    .we_i    (pix_valid),
    .addr_i  (pos_col),
    .wdata_i (pix_in),
    .rdata_o (line0_rd)
  );

  conv_line_ram #(
    .DEPTH  (IMG_W),
    .WIDTH  (BIT_WIDTH),
    .ADDR_W (COL_W)
  ) u_line1 (
    .clk     (clk),
    .we_i    (pix_valid),
    .addr_i  (pos_col),
    .wdata_i (line0_rd),
    .rdata_o (line1_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      top_q        <= '0;
      mid_q        <= '0;
      bot_q        <= '0;
      col_en_q     <= 1'b0;
      win_pend_q   <= 1'b0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      top_q        <= top_d;
      mid_q        <= mid_d;
      bot_q        <= bot_d;
      col_en_q     <= pix_valid;
      win_pend_q   <= pix_valid & win_now;
      // Extra stage: the window stage latches on col_en and its result
      // settles in the following cycle.
      win_valid_q  <= win_pend_q;
      frame_done_q <= pix_valid & at_last_row & at_last_col;
    end
  end

  assign col_en     = col_en_q;
  assign out_top    = top_q;
  assign out_mid    = mid_q;
  assign out_bot    = bot_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv33_line_buffer.sv
module tb_conv33_line_buffer;

  localparam int BW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sof = 1'b0;
  logic          pix_valid = 1'b0;
  logic [BW-1:0] pix_in = '0;
  logic          col_en;
  logic [BW-1:0] out_top;
  logic [BW-1:0] out_mid;
  logic [BW-1:0] out_bot;
  logic          win_valid;
  logic          frame_done;

  conv33_line_buffer #(
    .BIT_WIDTH (BW),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sof        (sof),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
    .col_en     (col_en),
    .out_top    (out_top),
    .out_mid    (out_mid),
    .out_bot    (out_bot),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pixel position from raster rules, per-column history
  // of the last two pixels seen at that column, and the current frame image.
  int            m_row, m_col, cyc;
  bit            win_due [int];
  logic [BW-1:0] hist [W][$];
  logic [BW-1:0] img [H][W];
  logic [BW-1:0] exp_top, exp_mid, exp_bot;
  bit            exp_col_en, exp_fd, exp_win, hist_known;
  int            obs_win, obs_fd;

  task automatic clear_model();
    m_row = 0;
    m_col = 0;
    win_due.delete();
    for (int i = 0; i < W; i++) hist[i].delete();
    exp_top = '0;
    exp_mid = '0;
    exp_bot = '0;
    exp_col_en = 0;
    exp_fd = 0;
    hist_known = 1;
  endtask

  task automatic tick(input bit v, input bit s, input logic [BW-1:0] p);
    bit            frame_chk;
    logic [BW-1:0] f_top, f_mid;
    int            r, c;
    frame_chk = 0;
    f_top = '0;
    f_mid = '0;
    pix_valid = v;
    sof = s;
    pix_in = p;
    @(posedge clk);
    cyc++;
    exp_col_en = 0;
    exp_fd = 0;
    if (!rst_n) begin
      clear_model();
    end else if (v) begin
      r = s ? 0 : m_row;
      c = s ? 0 : m_col;
      if (hist[c].size() >= 2) begin
        exp_top = hist[c][0];
        exp_mid = hist[c][1];
        hist_known = 1;
      end else begin
        hist_known = 0;
      end
      exp_bot = p;
      hist[c].push_back(p);
      if (hist[c].size() > 2) void'(hist[c].pop_front());
      img[r][c] = p;
      exp_col_en = 1;
      if (r >= 2 && c >= 2) begin
        win_due[cyc + 1] = 1;
        frame_chk = 1;
        f_top = img[r-2][c];
        f_mid = img[r-1][c];
      end
      exp_fd = (r == H - 1) && (c == W - 1);
      m_col = c + 1;
      m_row = r;
      if (m_col == W) begin
        m_col = 0;
        m_row = (r == H - 1) ? 0 : r + 1;
      end
    end
    exp_win = win_due.exists(cyc);
    if (exp_win) win_due.delete(cyc);
    #1;
    if (win_valid) obs_win++;
    if (frame_done) obs_fd++;
    check_val("col_en", 32'(col_en), 32'(exp_col_en));
    check_val("win_valid", 32'(win_valid), 32'(exp_win));
    check_val("frame_done", 32'(frame_done), 32'(exp_fd));
    check_val("out_bot", 32'(out_bot), 32'(exp_bot));
    if (hist_known) begin
      check_val("out_top", 32'(out_top), 32'(exp_top));
      check_val("out_mid", 32'(out_mid), 32'(exp_mid));
    end
    if (frame_chk) begin
      check_val("win_col_top", 32'(out_top), 32'(f_top));
      check_val("win_col_mid", 32'(out_mid), 32'(f_mid));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic send_pixels(input int n, input bit first_sof, input bit gapped, input int salt);
    for (int k = 0; k < n; k++) begin
      if (gapped) idle($urandom_range(0, 2));
      tick(1'b1, first_sof && (k == 0), 8'(16 * (k / W) + (k % W) + salt));
    end
  endtask

  task automatic check_frame_counts(input string tag, input int wins, input int fds);
    check_val({tag, "_win_count"}, 32'(obs_win), 32'(wins));
    check_val({tag, "_fd_count"}, 32'(obs_fd), 32'(fds));
    obs_win = 0;
    obs_fd = 0;
  endtask

  initial begin
    cyc = 0;
    obs_win = 0;
    obs_fd = 0;
    clear_model();

    // Reset held with random strobes: everything stays zero.
    rst_n = 1'b0;
    repeat (4) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    rst_n = 1'b1;

    // First pixel after reset lands at (0,0).
    tick(1'b1, 1'b0, 8'h05);
    idle(2);

    // Back-to-back frame with sof.
    obs_win = 0;
    obs_fd = 0;
    send_pixels(W * H, 1'b1, 1'b0, 0);
    idle(3);
    check_frame_counts("b2b", 4, 1);

    // Same frame, gapped strobes.
    send_pixels(W * H, 1'b1, 1'b1, 0);
    idle(3);
    check_frame_counts("gapped", 4, 1);

    // sof lands on what would be pixel (2,1): partial frame discarded.
    send_pixels(2 * W + 1, 1'b1, 1'b0, 8'h40);
    send_pixels(W * H, 1'b1, 1'b0, 8'h80);
    idle(3);
    check_frame_counts("abort", 4, 1);

    // Async reset pulse arriving after pixel (3,0) would have been next.
    send_pixels(3 * W, 1'b1, 1'b0, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_col_en", 32'(col_en), 32'd0);
    check_val("async_top", 32'(out_top), 32'd0);
    check_val("async_mid", 32'(out_mid), 32'd0);
    check_val("async_bot", 32'(out_bot), 32'd0);
    check_val("async_win", 32'(win_valid), 32'd0);
    check_val("async_fd", 32'(frame_done), 32'd0);
    clear_model();
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'h77);
    rst_n = 1'b1;
    obs_win = 0;
    obs_fd = 0;
    send_pixels(W * H, 1'b1, 1'b0, 8'h30);
    idle(3);
    check_frame_counts("post_reset", 4, 1);

    // Two consecutive frames, no sof on the second.
    send_pixels(W * H, 1'b1, 1'b0, 8'h11);
    idle(3);
    check_frame_counts("wrap_f1", 4, 1);
    send_pixels(W * H, 1'b0, 1'b0, 8'h99);
    idle(3);
    check_frame_counts("wrap_f2", 4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
